// File: rtl/hilo_md_ctrl_if.sv
// hilo_md_ctrl_if: EX-stage hilo op request bundle and the HI/LO write-back it produces.
interface hilo_md_ctrl_if #(
  parameter int W = 32
);
  logic         op_valid;
  logic [5:0]   op_sel;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         annul;
  logic         stallreq;
  logic         busy;
  logic [1:0]   hilo_we;
  logic [W-1:0] hi_wdata;
  logic [W-1:0] lo_wdata;

  modport master (
    output op_valid, op_sel, src_a, src_b, annul,
    input  stallreq, busy, hilo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  op_valid, op_sel, src_a, src_b, annul,
    output stallreq, busy, hilo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: EX-stage HI/LO sequencer with radix-2 divider and multiplier.
// Define HILO_MD_FAST_MUL_EN to replace the shift-add multiply with a single-cycle W x W multiply.
module hilo_md_ctrl #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  hilo_md_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic [W-1:0]     opa_q;
  logic [W-1:0]     opb_q;
  logic [W-1:0]     dividend_q;
  logic [W-1:0]     res_hi_q;
  logic [W-1:0]     res_lo_q;
  logic [2*W-1:0]   acc_q;

  logic             sel_div;
  logic             sel_divu;
  logic             sel_mult;
  logic             sel_multu;
  logic             sel_mthi;
  logic             sel_mtlo;
  logic             accept_div;
  logic             accept_md;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;

  logic             div_fits;
  logic [W-1:0]     div_rem;
  logic [2*W-1:0]   div_step;
  logic [2*W-1:0]   mul_step;
  logic [2*W-1:0]   acc_next;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;
  logic [W-1:0]     fin_hi;
  logic [W-1:0]     fin_lo;
  logic             run_last;

  logic             stallreq;
  logic             busy;
  logic [1:0]       hilo_we;
  logic [W-1:0]     hi_wdata;
  logic [W-1:0]     lo_wdata;

  // Priority decode: div > divu > mult > multu > mthi > mtlo; an annulled op is never seen.
  always_comb begin
    sel_div   = 1'b0;
    sel_divu  = 1'b0;
    sel_mult  = 1'b0;
    sel_multu = 1'b0;
    sel_mthi  = 1'b0;
    sel_mtlo  = 1'b0;
    if (bus.op_valid && !bus.annul) begin
      if (bus.op_sel[5])      sel_div   = 1'b1;
      else if (bus.op_sel[4]) sel_divu  = 1'b1;
      else if (bus.op_sel[3]) sel_mult  = 1'b1;
      else if (bus.op_sel[2]) sel_multu = 1'b1;
      else if (bus.op_sel[1]) sel_mthi  = 1'b1;
      else if (bus.op_sel[0]) sel_mtlo  = 1'b1;
    end
    accept_div = sel_div | sel_divu;
    accept_md  = accept_div | sel_mult | sel_multu;
    op_signed  = sel_div | sel_mult;
    sign_a     = op_signed & bus.src_a[W-1];
    sign_b     = op_signed & bus.src_b[W-1];
    mag_a      = sign_a ? -bus.src_a : bus.src_a;
    mag_b      = sign_b ? -bus.src_b : bus.src_b;
  end

  // The shifted partial remainder can reach W+1 bits, so the trial compare is done one bit wider.
  always_comb begin
    div_fits = acc_q[2*W-1:W-1] >= {1'b0, opb_q};
    div_rem  = acc_q[2*W-2:W-1] - opb_q;
    div_step = div_fits ? {div_rem, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
`ifdef HILO_MD_FAST_MUL_EN
    mul_step = {{W{1'b0}}, opa_q} * {{W{1'b0}}, opb_q};
    run_last = !is_div_q || (cnt_q == LAST_CNT);
`else
    mul_step = acc_q;
    if (opb_q[cnt_q[$clog2(W)-1:0]]) begin
      mul_step = acc_q + ({{W{1'b0}}, opa_q} << cnt_q);
    end
    run_last = (cnt_q == LAST_CNT);
`endif
    acc_next = is_div_q ? div_step : mul_step;
    quo      = acc_next[W-1:0];
    rem      = acc_next[2*W-1:W];
    prod     = neg_lo_q ? -acc_next : acc_next;
    if (is_div_q) begin
      fin_lo = neg_lo_q ? -quo : quo;
      fin_hi = neg_hi_q ? -rem : rem;
    end else begin
      fin_lo = prod[W-1:0];
      fin_hi = prod[2*W-1:W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    hilo_we  = 2'b00;
    hi_wdata = '0;
    lo_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_mthi) begin
          hilo_we  = 2'b10;
          hi_wdata = bus.src_a;
        end else if (sel_mtlo) begin
          hilo_we  = 2'b01;
          lo_wdata = bus.src_a;
        end else if (accept_md) begin
          stallreq = 1'b1;
          state_d  = (accept_div && (bus.src_b == '0)) ? DIVZERO : RUN;
        end
      end
      DIVZERO: begin
        stallreq = 1'b1;
        state_d  = DONE;
      end
      RUN: begin
        stallreq = 1'b1;
        if (run_last) state_d = DONE;
      end
      DONE: begin
        hilo_we  = 2'b11;
        hi_wdata = res_hi_q;
        lo_wdata = res_lo_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush kills whatever is in flight, including a result about to be written.
    if (bus.annul) begin
      state_d  = IDLE;
      hilo_we  = 2'b00;
      hi_wdata = '0;
      lo_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      dividend_q <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      acc_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_md) begin
            is_div_q   <= accept_div;
            neg_lo_q   <= sign_a ^ sign_b;
            neg_hi_q   <= sign_a;
            opa_q      <= mag_a;
            opb_q      <= mag_b;
            dividend_q <= bus.src_a;
            acc_q      <= accept_div ? {{W{1'b0}}, mag_a} : '0;
            cnt_q      <= '0;
          end
        end
        DIVZERO: begin
          res_lo_q <= '1;
          res_hi_q <= dividend_q;
        end
        RUN: begin
          acc_q <= acc_next;
          if (run_last) begin
            cnt_q    <= '0;
            res_hi_q <= fin_hi;
            res_lo_q <= fin_lo;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (bus.annul) cnt_q <= '0;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bus.stallreq = stallreq;
  assign bus.busy     = busy;
  assign bus.hilo_we  = hilo_we;
  assign bus.hi_wdata = hi_wdata;
  assign bus.lo_wdata = lo_wdata;

endmodule
